// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for load-use, EX branch flush and multi-cycle mul/div; perf counters under PIPE_PERF_CNT_EN.
// Zero-latency combinational controls from state/count/hazards; backpressures the front end only by dropping PCWrite/IFID_Write.
module pipe_stall_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rd_Addr_EX,
  input  logic [4:0]       Rs_Addr_ID,
  input  logic [4:0]       Rt_Addr_ID,
  input  logic             MulDiv_ID,
  input  logic             Branch_Taken_EX,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MulDiv_Go,
  output logic             MulDiv_Abort,
  output logic             MulDiv_Busy,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] MD_LOAD = 5'(MD_LAT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic       w_lu;

  assign w_lu = MemRead_EX && (Rd_Addr_EX != 5'd0) &&
                ((Rd_Addr_EX == Rs_Addr_ID) || (Rd_Addr_EX == Rt_Addr_ID));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MulDiv_Go    = 1'b0;
    MulDiv_Abort = 1'b0;
    MulDiv_Busy  = 1'b0;
    if (rst_i) begin
      MulDiv_Busy = (r_state == ST_MD_BUSY);
      case (r_state)
        ST_RUN: begin
          if (Branch_Taken_EX) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (w_lu) begin
            // The mul/div (if any) retries next cycle once the load has moved on.
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (MulDiv_ID) begin
            MulDiv_Go   = 1'b1;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            w_cnt_nxt   = MD_LOAD;
            w_state_nxt = ST_MD_BUSY;
          end
        end
        ST_MD_BUSY: begin
          if (Branch_Taken_EX) begin
            // An older branch in EX squashes the mul/div still waiting in ID.
            MulDiv_Abort = 1'b1;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            w_cnt_nxt    = 5'd0;
            w_state_nxt  = ST_RUN;
          end else if (r_cnt != 5'd0) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            w_cnt_nxt   = r_cnt - 5'd1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 5'd0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (IFID_Flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign Stall_Cycles = r_stall_cnt;
  assign Flush_Count  = r_flush_cnt;
`else
  assign Stall_Cycles = '0;
  assign Flush_Count  = '0;
`endif

  a_go_abort_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(MulDiv_Go && MulDiv_Abort));
  a_pc_ifid_match: assert property (@(posedge clk_i) disable iff (!rst_i)
    PCWrite == IFID_Write);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned CNT_W = 16;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Go, Abort, Busy}
  localparam logic [7:0] IDLE = 8'b1100_0000;
  localparam logic [7:0] LUST = 8'b0010_0000;
  localparam logic [7:0] GO   = 8'b0010_0100;
  localparam logic [7:0] BSTL = 8'b0010_0001;
  localparam logic [7:0] REL  = 8'b1100_0001;
  localparam logic [7:0] BRR  = 8'b1101_1000;
  localparam logic [7:0] ABT  = 8'b1101_1011;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             MemRead_EX = 1'b0;
  logic [4:0]       Rd_Addr_EX = 5'd0;
  logic [4:0]       Rs_Addr_ID = 5'd0;
  logic [4:0]       Rt_Addr_ID = 5'd0;
  logic             MulDiv_ID = 1'b0;
  logic             Branch_Taken_EX = 1'b0;
  logic             PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush;
  logic             MulDiv_Go, MulDiv_Abort, MulDiv_Busy;
  logic [CNT_W-1:0] Stall_Cycles, Flush_Count;
  logic [7:0]       obs;

  int vectors = 0;
  int errs    = 0;

  assign obs = {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush,
                MulDiv_Go, MulDiv_Abort, MulDiv_Busy};

  pipe_stall_ctrl #(.MD_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_EX(MemRead_EX), .Rd_Addr_EX(Rd_Addr_EX),
    .Rs_Addr_ID(Rs_Addr_ID), .Rt_Addr_ID(Rt_Addr_ID),
    .MulDiv_ID(MulDiv_ID), .Branch_Taken_EX(Branch_Taken_EX),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MulDiv_Go(MulDiv_Go), .MulDiv_Abort(MulDiv_Abort), .MulDiv_Busy(MulDiv_Busy),
    .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input bit mr, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input bit md, input bit br);
    MemRead_EX = mr; Rd_Addr_EX = rd; Rs_Addr_ID = rs; Rt_Addr_ID = rt;
    MulDiv_ID = md; Branch_Taken_EX = br;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    next_cycle;
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL reset_outs: got %b want %b", obs, IDLE); end
    vectors++; if (Stall_Cycles !== '0 || Flush_Count !== '0) begin errs++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", Stall_Cycles, Flush_Count); end
    do_reset;
    set_in(0, 0, 0, 0, 1, 0);
    vectors++; if (obs !== GO) begin errs++; $display("FAIL rst_go: got %b want %b", obs, GO); end
    next_cycle;
    vectors++; if (obs !== BSTL) begin errs++; $display("FAIL rst_busy: got %b want %b", obs, BSTL); end
    @(negedge clk_i); rst_i = 1'b0;
    set_in(1, 3, 3, 0, 1, 1);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL rst_forced: got %b want %b", obs, IDLE); end
    @(negedge clk_i);
    set_in(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1; #1;
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL rst_release: got %b want %b", obs, IDLE); end
    next_cycle;
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL rst_no_abort: got %b want %b", obs, IDLE); end
  endtask

  task automatic test_load_use;
    do_reset;
    set_in(1, 5, 3, 5, 0, 0);
    vectors++; if (obs !== LUST) begin errs++; $display("FAIL lu_rt: got %b want %b", obs, LUST); end
    next_cycle;
    set_in(0, 5, 3, 5, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL lu_one_cycle: got %b want %b", obs, IDLE); end
    next_cycle;
    set_in(1, 9, 9, 2, 0, 0);
    vectors++; if (obs !== LUST) begin errs++; $display("FAIL lu_rs: got %b want %b", obs, LUST); end
    next_cycle;
    set_in(1, 0, 0, 0, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL lu_r0: got %b want %b", obs, IDLE); end
    next_cycle;
    set_in(1, 5, 6, 7, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL lu_nomatch: got %b want %b", obs, IDLE); end
    next_cycle;
  endtask

  task automatic test_muldiv(input bit with_lu);
    logic [7:0] exp;
    do_reset;
    if (with_lu) begin
      set_in(1, 7, 7, 0, 1, 0);
      vectors++; if (obs !== LUST) begin errs++; $display("FAIL lumd_lu: got %b want %b", obs, LUST); end
      next_cycle;
    end
    for (int k = 0; k <= int'(LAT); k++) begin
      if (k == 2) set_in(1, 4, 4, 4, 1, 0);
      else        set_in(0, 0, 0, 0, 1, 0);
      exp = (k == 0) ? GO : (k < int'(LAT)) ? BSTL : REL;
      vectors++; if (obs !== exp) begin errs++;
        $display("FAIL md_seq lu=%0d k=%0d: got %b want %b", with_lu, k, obs, exp); end
      next_cycle;
    end
    set_in(0, 0, 0, 0, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL md_after: got %b want %b", obs, IDLE); end
    next_cycle;
  endtask

  task automatic test_branch_abort;
    do_reset;
    set_in(0, 0, 0, 0, 1, 0);
    vectors++; if (obs !== GO) begin errs++; $display("FAIL ab_go: got %b want %b", obs, GO); end
    next_cycle;
    set_in(0, 0, 0, 0, 1, 0);
    vectors++; if (obs !== BSTL) begin errs++; $display("FAIL ab_busy: got %b want %b", obs, BSTL); end
    next_cycle;
    set_in(0, 0, 0, 0, 1, 1);
    vectors++; if (obs !== ABT) begin errs++; $display("FAIL ab_abort: got %b want %b", obs, ABT); end
    next_cycle;
    set_in(0, 0, 0, 0, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL ab_run: got %b want %b", obs, IDLE); end
    next_cycle;
    set_in(1, 5, 5, 0, 1, 1);
    vectors++; if (obs !== BRR) begin errs++; $display("FAIL br_prio: got %b want %b", obs, BRR); end
    next_cycle;
    set_in(0, 0, 0, 0, 0, 0);
    vectors++; if (obs !== IDLE) begin errs++; $display("FAIL br_after: got %b want %b", obs, IDLE); end
    next_cycle;
  endtask

  task automatic test_perf;
    int n;
    do_reset;
    for (int k = 0; k <= int'(LAT); k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      next_cycle;
    end
    set_in(0, 0, 0, 0, 0, 1);
    next_cycle;
    set_in(0, 0, 0, 0, 0, 0);
    vectors++; if (Stall_Cycles !== (PERF ? CNT_W'(LAT) : '0)) begin errs++;
      $display("FAIL perf_stall: got %0d want %0d", Stall_Cycles, PERF ? LAT : 0); end
    vectors++; if (Flush_Count !== (PERF ? CNT_W'(1) : '0)) begin errs++;
      $display("FAIL perf_flush: got %0d want %0d", Flush_Count, PERF ? 1 : 0); end
    n = PERF ? (1 << CNT_W) + 4 : 16;
    set_in(1, 5, 5, 5, 0, 0);
    repeat (n) @(posedge clk_i);
    #1;
    set_in(0, 0, 0, 0, 0, 0);
    vectors++; if (Stall_Cycles !== (PERF ? CNT_MAX : '0)) begin errs++;
      $display("FAIL perf_sat: got %0h want %0h", Stall_Cycles, PERF ? CNT_MAX : '0); end
    vectors++; if (Flush_Count !== (PERF ? CNT_W'(1) : '0)) begin errs++;
      $display("FAIL perf_flush_hold: got %0d want %0d", Flush_Count, PERF ? 1 : 0); end
    next_cycle;
  endtask

  task automatic test_random;
    bit         mr, md, br, lu, md_live;
    logic [4:0] rd, rs, rt;
    logic [7:0] exp;
    int         go_cyc, m_stall, m_flush;
    logic [CNT_W-1:0] exp_s, exp_f;
    do_reset;
    md_live = 1'b0; go_cyc = 0; m_stall = 0; m_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      mr = ($urandom % 3) == 0;
      rd = 5'($urandom % 4);
      rs = 5'($urandom % 4);
      rt = 5'($urandom % 4);
      md = ($urandom % 5) == 0;
      br = ($urandom % 7) == 0;
      set_in(mr, rd, rs, rt, md, br);
      lu = mr && (rd != 0) && (rd == rs || rd == rt);
      if (md_live) begin
        if (br) begin exp = ABT; md_live = 1'b0; end
        else if (c == go_cyc + int'(LAT)) begin exp = REL; md_live = 1'b0; end
        else exp = BSTL;
      end else if (br) exp = BRR;
      else if (lu) exp = LUST;
      else if (md) begin exp = GO; md_live = 1'b1; go_cyc = c; end
      else exp = IDLE;
      exp_s = PERF ? ((m_stall > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(m_stall)) : '0;
      exp_f = PERF ? ((m_flush > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(m_flush)) : '0;
      vectors++; if (obs !== exp) begin errs++;
        $display("FAIL rnd_outs c=%0d: got %b want %b", c, obs, exp); end
      vectors++; if (Stall_Cycles !== exp_s || Flush_Count !== exp_f) begin errs++;
        $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, Stall_Cycles, Flush_Count, exp_s, exp_f); end
      if (!exp[7]) m_stall++;
      if (exp[4])  m_flush++;
      next_cycle;
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_muldiv(1'b0);
    test_muldiv(1'b1);
    test_branch_abort;
    test_random;
    test_perf;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
